// File: rtl/univ_shift_reg_if.sv
// Purpose : bundles the control, data and status signals of univ_shift_reg.
// Ports   : enable/mode/start/amount/pin/sin_l/sin_r flow master -> slave;
//           q/sout_l/sout_r/busy/done flow slave -> master.
interface univ_shift_reg_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
);
   logic             enable;
   logic [2:0]       mode;
   logic             start;
   logic [CNT_W-1:0] amount;
   logic [WIDTH-1:0] pin;
   logic             sin_l;
   logic             sin_r;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;

   modport master (
      output enable, mode, start, amount, pin, sin_l, sin_r,
      input  q, sout_l, sout_r, busy, done
   );

   modport slave (
      input  enable, mode, start, amount, pin, sin_l, sin_r,
      output q, sout_l, sout_r, busy, done
   );
endinterface

// File: rtl/univ_shift_reg.sv
// Purpose : WIDTH-bit universal shift register with global enable, eight
//           single-step modes and a multi-cycle "shift by N" command with
//           a busy/done handshake.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous active-low reset
//           bus    - univ_shift_reg_if.slave (enable, mode, start, amount,
//                    pin, sin_l, sin_r in; q, sout_l, sout_r, busy, done out)
module univ_shift_reg #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input logic               clk,
   input logic               rst_n,
   univ_shift_reg_if.slave   bus
);

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_LOAD  = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_SHR   = 3'b011;
   localparam logic [2:0] M_ROTL  = 3'b100;
   localparam logic [2:0] M_ROTR  = 3'b101;
   localparam logic [2:0] M_ASR   = 3'b110;
   localparam logic [2:0] M_CLEAR = 3'b111;

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // One step of the selected operation applied to the current contents.
   function automatic logic [WIDTH-1:0] step_f(
      input logic [2:0]       m,
      input logic [WIDTH-1:0] v,
      input logic [WIDTH-1:0] p,
      input logic             sl,
      input logic             sr
   );
      logic [WIDTH-1:0] r;
      r = v;
      case (m)
         M_HOLD:  r = v;
         M_LOAD:  r = p;
         M_SHL:   r = {v[WIDTH-2:0], sr};
         M_SHR:   r = {sl, v[WIDTH-1:1]};
         M_ROTL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
         M_ROTR:  r = {v[0], v[WIDTH-1:1]};
         M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
         M_CLEAR: r = '0;
         default: r = v;
      endcase
      return r;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         cnt_q   <= '0;
         mode_q  <= M_HOLD;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and datapath; done defaults low so it is a single-cycle pulse
   // even when enable drops.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (bus.enable) begin
         case (state_q)
            IDLE: begin
               if (!bus.start) begin
                  q_d = step_f(bus.mode, q_q, bus.pin, bus.sin_l, bus.sin_r);
               end else if (bus.amount == '0) begin
                  done_d = 1'b1;
               end else if (bus.mode == M_HOLD || bus.mode == M_LOAD ||
                            bus.mode == M_CLEAR) begin
                  // Non-repeatable modes complete in a single step.
                  q_d    = step_f(bus.mode, q_q, bus.pin, bus.sin_l, bus.sin_r);
                  done_d = 1'b1;
               end else begin
                  // Start edge only latches the command; q is untouched.
                  mode_d  = bus.mode;
                  cnt_d   = bus.amount;
                  busy_d  = 1'b1;
                  state_d = RUN;
               end
            end
            RUN: begin
               q_d   = step_f(mode_q, q_q, bus.pin, bus.sin_l, bus.sin_r);
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.q      = q_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.sout_l = q_q[WIDTH-1];
   assign bus.sout_r = q_q[0];

endmodule
